instr_mem_responder: RTL and testbench

- Multi-cycle instruction memory: the responding end of the CPU fetch interface.
- The CPU presents a byte address with `READ`. The block holds `BUSYWAIT` high for a fixed latency, then returns a little-endian 32-bit word for one cycle. The CPU stalls PC update while `BUSYWAIT` is high.
- A byte-wide load port lets a bench or boot loader fill the array without a file-based initialiser in the CPU path.

---
 rtl/instr_mem_responder_if.sv | 13 +
 rtl/instr_mem_responder.sv | 64 ++++++
 tb/tb_instr_mem_responder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/instr_mem_responder_if.sv
// instr_mem_responder_if: CPU fetch handshake and byte-load port of the instruction memory
interface instr_mem_responder_if;
  logic        READ;
  logic [31:0] ADDRESS;
  logic        BUSYWAIT;
  logic [31:0] READDATA;
  logic        ERROR;
  logic        LOAD_EN;
  logic [31:0] LOAD_ADDR;
  logic [7:0]  LOAD_DATA;
  modport master(output READ, ADDRESS, LOAD_EN, LOAD_ADDR, LOAD_DATA, input BUSYWAIT, READDATA, ERROR);
  modport slave(input READ, ADDRESS, LOAD_EN, LOAD_ADDR, LOAD_DATA, output BUSYWAIT, READDATA, ERROR);
endinterface

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: fixed-latency byte-addressed instruction memory answering CPU fetches
module instr_mem_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 4
) (
  input logic                  CLK,
  input logic                  RESET,
  instr_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_BYTES);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic [31:0] addr_q, addr_d, rdata, rdata_d, word;
  logic        error, error_d, bad;
  logic [AW-1:0] base;
  logic [7:0]  mem [DEPTH_BYTES];
  assign base = addr_q[AW-1:0];
  assign bad = (|addr_q[1:0]) || ({1'b0, addr_q} + 33'd3 >= 33'(DEPTH_BYTES));
  assign word = {mem[base + AW'(3)], mem[base + AW'(2)], mem[base + AW'(1)], mem[base]};
  assign bus.BUSYWAIT = RESET && ((state == IDLE && bus.READ) || state == WAIT);
  assign bus.READDATA = rdata;
  assign bus.ERROR = error;
  // next-state: accept in IDLE, count down the latency in WAIT, present the word for one DONE cycle
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    addr_d = addr_q;
    rdata_d = rdata;
    error_d = 1'b0;
    case (state)
      IDLE: if (bus.READ) begin
        addr_d = bus.ADDRESS;
        cnt_d = 4'(LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: if (cnt != 4'd0) cnt_d = cnt - 4'd1;
      else begin
        rdata_d = bad ? 32'h0 : word;
        error_d = bad;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register; an asynchronous reset drops any fetch in flight
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state <= IDLE;
      cnt <= 4'd0;
      addr_q <= 32'h0;
      rdata <= 32'h0;
      error <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      addr_q <= addr_d;
      rdata <= rdata_d;
      error <= error_d;
    end
  // byte loads land only while idle and in range; contents survive reset
  always_ff @(posedge CLK)
    if (state == IDLE && bus.LOAD_EN && bus.LOAD_ADDR < 32'(DEPTH_BYTES)) mem[bus.LOAD_ADDR[AW-1:0]] <= bus.LOAD_DATA;
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: scoreboard bench for the fetch responder (LATENCY 4 and LATENCY 1 builds)
module tb_instr_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  instr_mem_responder_if bus();
  instr_mem_responder_if bus1();
  instr_mem_responder dut (.CLK(clk), .RESET(rst_n), .bus(bus));
  instr_mem_responder #(.LATENCY(1)) dut1 (.CLK(clk), .RESET(rst_n), .bus(bus1));
  typedef struct {logic [31:0] d; logic e; int per;} exp_t;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int run = 0;
  int last_done = 0;
  logic prev = 1'b0;
  logic [31:0] hold = 32'h0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask
  // monitor: a DONE cycle is the first non-busy cycle after a busy run
  always @(negedge clk) begin
    exp_t x;
    cyc++;
    if (!rst_n) begin
      run = 0;
      prev = 1'b0;
      hold = 32'h0;
    end else if (bus.BUSYWAIT) begin
      run++;
      prev = 1'b1;
    end else if (prev) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got data %h, no expectation queued", bus.READDATA);
      end else begin
        x = q.pop_front();
        chk("readdata", bus.READDATA, x.d);
        chk("error", 32'(bus.ERROR), 32'(x.e));
        chk("busy_len", run, 5);
        if (x.per > 0) chk("period", cyc - last_done, x.per);
      end
      hold = bus.READDATA;
      last_done = cyc;
      run = 0;
      prev = 1'b0;
    end else begin
      chk("hold_readdata", bus.READDATA, hold);
      chk("idle_error", 32'(bus.ERROR), 32'h0);
    end
  end
  task automatic load(input logic [31:0] a, input logic [7:0] d);
    bus.LOAD_EN = 1'b1;
    bus.LOAD_ADDR = a;
    bus.LOAD_DATA = d;
    @(posedge clk); #1;
    bus.LOAD_EN = 1'b0;
  endtask
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic e, input int per,
                       input int chg_at, input int ld_at, input logic [31:0] la, input logic [7:0] ld, input bit keep);
    bit done = 0;
    q.push_back('{d, e, per});
    bus.READ = 1'b1;
    bus.ADDRESS = a;
    if (ld_at == 0) begin
      bus.LOAD_EN = 1'b1;
      bus.LOAD_ADDR = la;
      bus.LOAD_DATA = ld;
    end
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      bus.LOAD_EN = 1'b0;
      if (i == chg_at) bus.ADDRESS = a ^ 32'h40;
      if (i == ld_at) begin
        bus.LOAD_EN = 1'b1;
        bus.LOAD_ADDR = la;
        bus.LOAD_DATA = ld;
      end
      if (!bus.BUSYWAIT) begin
        done = 1;
        break;
      end
    end
    bus.LOAD_EN = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: addr %h still busy, want DONE within 40 cycles", a);
    end
    if (!keep) begin
      bus.READ = 1'b0;
      @(posedge clk); #1;
    end
  endtask
  initial begin
    logic [7:0] img [12] = '{8'h13, 8'h02, 8'h00, 8'h01, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    logic [7:0] b1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus.READ = 1'b0; bus.ADDRESS = 32'h0; bus.LOAD_EN = 1'b0; bus.LOAD_ADDR = 32'h0; bus.LOAD_DATA = 8'h0;
    bus1.READ = 1'b0; bus1.ADDRESS = 32'h0; bus1.LOAD_EN = 1'b0; bus1.LOAD_ADDR = 32'h0; bus1.LOAD_DATA = 8'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) load(32'(i), img[i]);
    load(32'd1020, 8'hEF); load(32'd1021, 8'hBE); load(32'd1022, 8'hAD); load(32'd1023, 8'hDE);
    load(32'd1024, 8'hAA);
    rst_n = 1'b0;
    #1;
    chk("reset_busywait", 32'(bus.BUSYWAIT), 32'h0);
    chk("reset_readdata", bus.READDATA, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    fetch(32'd0, 32'h0100_0213, 1'b0, 0, 0, -1, 0, 0, 0);
    fetch(32'd0, 32'h0100_0213, 1'b0, 0, 0, -1, 0, 0, 1);
    fetch(32'd4, 32'h0050_0093, 1'b0, 6, 2, -1, 0, 0, 1);
    fetch(32'd8, 32'h00A0_0113, 1'b0, 6, 0, -1, 0, 0, 0);
    bus.READ = 1'b1;
    bus.ADDRESS = 32'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busywait", 32'(bus.BUSYWAIT), 32'h0);
    chk("abort_readdata", bus.READDATA, 32'h0);
    chk("abort_error", 32'(bus.ERROR), 32'h0);
    bus.READ = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    fetch(32'd0, 32'h0100_0213, 1'b0, 0, 0, -1, 0, 0, 0);
    fetch(32'd2, 32'h0, 1'b1, 0, 0, -1, 0, 0, 0);
    fetch(32'd1024, 32'h0, 1'b1, 0, 0, -1, 0, 0, 0);
    fetch(32'd1020, 32'hDEAD_BEEF, 1'b0, 0, 0, -1, 0, 0, 0);
    fetch(32'd1021, 32'h0, 1'b1, 0, 0, -1, 0, 0, 0);
    fetch(32'hFFFF_FFFC, 32'h0, 1'b1, 0, 0, -1, 0, 0, 0);
    fetch(32'd8, 32'h00A0_0113, 1'b0, 0, 0, 1, 32'd4, 8'hFF, 0);
    fetch(32'd4, 32'h0050_0093, 1'b0, 0, 0, -1, 0, 0, 0);
    fetch(32'd0, 32'h0100_0277, 1'b0, 0, 0, 0, 32'd0, 8'h77, 0);
    for (int i = 0; i < 4; i++) begin
      bus1.LOAD_EN = 1'b1;
      bus1.LOAD_ADDR = 32'(i);
      bus1.LOAD_DATA = b1[i];
      @(posedge clk); #1;
    end
    bus1.LOAD_EN = 1'b0;
    bus1.READ = 1'b1;
    bus1.ADDRESS = 32'd0;
    #1;
    chk("l1_busy_request", 32'(bus1.BUSYWAIT), 32'h1);
    @(posedge clk); #1;
    chk("l1_busy_wait", 32'(bus1.BUSYWAIT), 32'h1);
    @(posedge clk); #1;
    chk("l1_busy_done", 32'(bus1.BUSYWAIT), 32'h0);
    chk("l1_readdata", bus1.READDATA, 32'h4433_2211);
    chk("l1_error", 32'(bus1.ERROR), 32'h0);
    bus1.READ = 1'b0;
    @(posedge clk); #1;
    chk("l1_hold", bus1.READDATA, 32'h4433_2211);
    repeat (3) @(posedge clk);
    #1 chk("queue_empty", q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
